// File: rtl/layer_bram_responder_pkg.sv
// Shared layer-engine constants: data size, layer base addresses,
// BRAM geometry, common read latency and a saturating-count helper.
package layer_bram_responder_pkg;

  localparam int DATA_SIZE         = 8;
  localparam int BRAM_ADDR_W       = 15;
  localparam int BRAM_DEPTH        = 19000;
  localparam int POOL2_RESULT_BASE = 17600;
  localparam int FC1_RESULT_BASE   = 18400;
  localparam int RD_LATENCY        = 2;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] c
  );
    return (c == CNT_MAX) ? c : c + 32'd1;
  endfunction

endpackage

// File: rtl/layer_bram_responder_if.sv
// Layer-engine BRAM port bundle: engine (master) side drives the
// request, responder (slave) side returns data, strobe and debug state.
interface layer_bram_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
);
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;
  logic              rd_vld;
  logic [31:0]       rd_count;
  logic [31:0]       wr_count;
  logic              oor_err;
  logic [ADDR_W-1:0] oor_addr;

  modport master (
    output ena, wea, addra, dina,
    input  douta, rd_vld, rd_count,
    input  wr_count, oor_err, oor_addr
  );

  modport slave (
    input  ena, wea, addra, dina,
    output douta, rd_vld, rd_count,
    output wr_count, oor_err, oor_addr
  );
endinterface

// File: rtl/layer_bram_responder_bram_sp_core.sv
// Single-port RAM array with an enabled stage-1 read register,
// shaped so synthesis maps it onto block RAM with its output register.
module bram_sp_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 19000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic              i_ok,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  // in-range writes only; contents survive reset
  always_ff @(posedge clk) begin
    if (i_en && i_we && i_ok) begin
      r_mem[i_addr] <= i_din;
    end
  end

  // stage 1: sample the array on a read, zero for out-of-range
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en && !i_we) begin
      r_q <= i_ok ? r_mem[i_addr] : '0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/layer_bram_responder.sv
// Layer BRAM responder: RAM core, read latency pipeline, rd_vld strobe,
// saturating access counters. RESP_OOR_CHECK_EN adds sticky oor_err/oor_addr.
module layer_bram_responder
  import layer_bram_responder_pkg::*;
#(
  parameter int DATA_W       = DATA_SIZE,
  parameter int ADDR_W       = BRAM_ADDR_W,
  parameter int DEPTH        = BRAM_DEPTH,
  parameter int READ_LATENCY = RD_LATENCY
) (
  input logic                  clk,
  input logic                  rst,
  layer_bram_responder_if.slave bus
);

  logic              w_rd;
  logic              w_wr;
  logic              w_ok;
  logic [DATA_W-1:0] w_q1;
  logic [DATA_W-1:0] w_dout;

  logic [READ_LATENCY:1] r_vld;
  logic [31:0]           r_rd_cnt;
  logic [31:0]           r_wr_cnt;

  assign w_rd = bus.ena && !bus.wea;
  assign w_wr = bus.ena && bus.wea;
  assign w_ok = bus.addra < ADDR_W'(DEPTH);

  bram_sp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .i_en   (bus.ena),
    .i_we   (bus.wea),
    .i_ok   (w_ok),
    .i_addr (bus.addra),
    .i_din  (bus.dina),
    .o_q    (w_q1)
  );

  // valid bits track each read down the pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld[1] <= w_rd;
      for (int k = 2; k <= READ_LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
    end
  end

  for (genvar k = 2; k <= READ_LATENCY; k++) begin : g_stg
    logic [DATA_W-1:0] r_d;
    logic [DATA_W-1:0] w_src;
    if (k == 2) begin : g_src
      assign w_src = w_q1;
    end else begin : g_src
      assign w_src = g_stg[k-1].r_d;
    end
    // stage k moves only live read data, so douta holds otherwise
    always_ff @(posedge clk) begin
      if (rst) begin
        r_d <= '0;
      end else if (r_vld[k-1]) begin
        r_d <= w_src;
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_out
    assign w_dout = w_q1;
  end else begin : g_out
    assign w_dout = g_stg[READ_LATENCY].r_d;
  end

  // access counters bump on the request edge and stick at max
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd) r_rd_cnt <= sat_inc(r_rd_cnt);
      if (w_wr) r_wr_cnt <= sat_inc(r_wr_cnt);
    end
  end

  assign bus.douta    = w_dout;
  assign bus.rd_vld   = r_vld[READ_LATENCY];
  assign bus.rd_count = r_rd_cnt;
  assign bus.wr_count = r_wr_cnt;

`ifdef RESP_OOR_CHECK_EN
  logic              r_oor_err;
  logic [ADDR_W-1:0] r_oor_addr;

  // first out-of-range request is latched until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_oor_err  <= 1'b0;
      r_oor_addr <= '0;
    end else if (bus.ena && !w_ok && !r_oor_err) begin
      r_oor_err  <= 1'b1;
      r_oor_addr <= bus.addra;
    end
  end

  assign bus.oor_err  = r_oor_err;
  assign bus.oor_addr = r_oor_addr;
`else
  assign bus.oor_err  = 1'b0;
  assign bus.oor_addr = '0;
`endif

endmodule

// File: tb/tb_layer_bram_responder.sv
// Scoreboard bench for layer_bram_responder: random and directed
// traffic against an associative-array memory model.
module tb_layer_bram_responder;
  import layer_bram_responder_pkg::*;

  localparam int L     = RD_LATENCY;
  localparam int DEPTH = BRAM_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_bram_responder_if #(
    .DATA_W (8),
    .ADDR_W (15)
  ) bus ();

  layer_bram_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  bit   rst_edge = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0]  mem_m [int];
  logic [31:0] rd_m = 0;
  logic [31:0] wr_m = 0;
  bit          oor_m = 0;
  logic [14:0] oor_addr_m = 0;
  logic [7:0]  last = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  function automatic logic [31:0] sat(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 1;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, a, e, cyc);
    end
  endtask

  task automatic issue(input bit en, input bit we,
                       input logic [14:0] a,
                       input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    bus.ena   = en;
    bus.wea   = we;
    bus.addra = a;
    bus.dina  = d;
    if (en) begin
      if (!oor_m && int'(a) >= DEPTH) begin
        oor_m      = 1;
        oor_addr_m = a;
      end
      if (we) begin
        wr_m = sat(wr_m);
        if (int'(a) < DEPTH) mem_m[int'(a)] = d;
      end else begin
        rd_m  = sat(rd_m);
        e.d   = (int'(a) < DEPTH) ? mem_m[int'(a)] : 8'h00;
        e.due = cyc + L;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 15'd0, 8'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    bus.ena = 1'b0;
    rd_m    = 0;
    wr_m    = 0;
    oor_m   = 0;
    oor_addr_m = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_state(input string nm);
    chk({nm, "_rd_count"}, bus.rd_count, rd_m);
    chk({nm, "_wr_count"}, bus.wr_count, wr_m);
`ifdef RESP_OOR_CHECK_EN
    chk({nm, "_oor_err"}, {31'd0, bus.oor_err}, {31'd0, oor_m});
    chk({nm, "_oor_addr"}, {17'd0, bus.oor_addr}, {17'd0, oor_addr_m});
`else
    chk({nm, "_oor_err"}, {31'd0, bus.oor_err}, 32'd0);
    chk({nm, "_oor_addr"}, {17'd0, bus.oor_addr}, 32'd0);
`endif
  endtask

  // monitor: pops the scoreboard whenever rd_vld is seen
  always @(negedge clk) begin
    exp_t e;
    if (rst_edge) begin
      q.delete();
      last = 0;
      chk("rst_douta", {24'd0, bus.douta}, 32'd0);
      chk("rst_rd_vld", {31'd0, bus.rd_vld}, 32'd0);
    end else if (bus.rd_vld) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_rd_vld: got 1 expected 0 (cycle %0d)",
                 cyc);
      end else begin
        e = q.pop_front();
        chk("rd_data", {24'd0, bus.douta}, {24'd0, e.d});
        chk("rd_cycle", cyc, e.due);
        last = e.d;
      end
    end else begin
      chk("douta_hold", {24'd0, bus.douta}, {24'd0, last});
      if (q.size() != 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missing_rd_vld: got 0 expected 1 due %0d (cycle %0d)",
                 e.due, cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] a;
    int          r;
    bus.ena   = 0;
    bus.wea   = 0;
    bus.addra = 0;
    bus.dina  = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_state("reset");

    // write then read same address on the next edge
    issue(1, 1, 15'(FC1_RESULT_BASE), 8'h5A);
    issue(1, 0, 15'(FC1_RESULT_BASE), 8'h00);
    idle(3);
    chk_state("wr_rd");

    // back-to-back pipelined reads
    for (int i = 0; i < 4; i++)
      issue(1, 1, 15'(POOL2_RESULT_BASE + i), 8'(i + 1));
    for (int i = 0; i < 4; i++)
      issue(1, 0, 15'(POOL2_RESULT_BASE + i), 8'd0);
    idle(4);
    chk_state("b2b");

    // engine cadence: addr, wait, wait, capture
    for (int i = 0; i < 500; i++)
      issue(1, 1, 15'(POOL2_RESULT_BASE + i), 8'($urandom));
    for (int i = 0; i < 500; i++) begin
      a = 15'(POOL2_RESULT_BASE + i);
      issue(1, 0, a, 8'd0);
      idle(2);
      chk("capture", {24'd0, bus.douta}, {24'd0, mem_m[int'(a)]});
      idle(1);
    end
    chk_state("cadence");

    // out-of-range read, then out-of-range write
    issue(1, 0, 15'd19000, 8'd0);
    idle(3);
    chk_state("oor_rd");
    issue(1, 1, 15'd19500, 8'hC3);
    issue(1, 0, 15'd19500, 8'd0);
    idle(3);
    chk_state("oor_wr");

    // random mixed traffic, mostly in a small window
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0)
        a = 15'($urandom_range(DEPTH, 32767));
      else
        a = 15'(POOL2_RESULT_BASE + $urandom_range(0, 63));
      issue(r < 12, $urandom_range(0, 2) == 0, a, 8'($urandom));
    end
    idle(4);
    chk_state("random");

    // reset one edge after a read request
    issue(1, 0, 15'(POOL2_RESULT_BASE + 5), 8'd0);
    do_reset();
    idle(4);
    chk_state("mid_rst");
    issue(1, 0, 15'(POOL2_RESULT_BASE + 5), 8'd0);
    idle(3);

    // saturation of the read counter
    @(negedge clk);
    force dut.r_rd_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_rd_cnt;
    rd_m = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++)
      issue(1, 0, 15'(POOL2_RESULT_BASE + i), 8'd0);
    idle(4);
    chk("sat_rd_count", bus.rd_count, 32'hFFFF_FFFF);
    chk_state("sat");

    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
